diff_integ: RTL and testbench

Stream integrator that inverts `diff`. Accepts signed first-difference samples of width INPUT_WIDTH+1 on a valid/ready input. Outputs the running sum, reconstructed to INPUT_WIDTH bits, on a valid/ready output. Sits downstream of `diff`, so that `diff` followed by `diff_integ` is an identity on the sample stream; used for round-trip checking and for decoding delta-coded streams.

---
 rtl/diff_integ.sv | 153 +++++++++++++++
 tb/tb_diff_integ.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/diff_integ.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// diff_integ -- stream integrator, the inverse of diff.
//
// Accepts signed first-difference samples and emits the running sum.
// The running sum wraps modulo 2^INPUT_WIDTH, so diff followed by diff_integ
// reproduces the original unsigned sample stream.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   difference sample present
//   in_ready_o   block can take a sample this cycle (registered, no path
//                from out_ready_i)
//   in_data_i    two's-complement difference, INPUT_WIDTH+1 bits
//   out_valid_o  reconstructed sample present
//   out_ready_i  consumer accepts this cycle
//   out_data_o   reconstructed unsigned sample, INPUT_WIDTH bits
//   overflow_o   sticky range-violation flag (only with DIFF_INTEG_OVF_EN)
//
// Build option:
//   DIFF_INTEG_OVF_EN  when defined, adds overflow_o. It is set on any
//                      transfer whose true sum leaves [0, 2^INPUT_WIDTH-1].
// ---------------------------------------------------------------------------
module diff_integ #(
  parameter int INPUT_WIDTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [INPUT_WIDTH:0]   in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
`ifdef DIFF_INTEG_OVF_EN
  output logic                   overflow_o,
`endif
  output logic [INPUT_WIDTH-1:0] out_data_o
);

  localparam int W = INPUT_WIDTH;

  // Occupancy of the two-entry output skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;
  logic [W+1:0] sumFull;
  logic [W-1:0] accNext;

  // Full-precision sum: zero-extended accumulator plus sign-extended
  // difference. The low W bits are the wrapped result; the top two bits are
  // nonzero exactly when the true sum lies outside [0, 2^W-1].
  assign sumFull = {2'b00, acc_q} + {in_data_i[W], in_data_i};
  assign accNext = sumFull[W-1:0];

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A push is impossible in FULL because in_ready_o is low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Output decode. Both handshake outputs depend on registered state only.
  always_comb begin
    in_ready_o  = (state_q != FULL);
    out_valid_o = (state_q != EMPTY);
    out_data_o  = head_q;
  end

  // Accumulator and buffer slots. head is always the entry on out_data_o.
  // A simultaneous push and pop in ONE replaces head directly. A pop from
  // FULL promotes tail into head.
  always_comb begin
    acc_d  = acc_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) acc_d = accNext;
    case (state_q)
      EMPTY: if (push) head_d = accNext;
      ONE: begin
        if (push && pop) head_d = accNext;
        else if (push)   tail_d = accNext;
      end
      FULL:  if (pop) head_d = tail_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      acc_q  <= acc_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifdef DIFF_INTEG_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky: once any accepted sum leaves the representable range, the flag
  // stays set until reset.
  always_comb begin
    ovf_d = ovf_q | (push && (sumFull[W+1:W] != 2'b00));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  // Without range checking, wrap-around is silent and the carry bits are
  // not needed.
  logic unusedSumMsbs;
  assign unusedSumMsbs = ^sumFull[W+1:W];
`endif

endmodule

// File: tb/tb_diff_integ.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_diff_integ -- self-checking bench for diff_integ.
//
// The reference model keeps a queue of the samples the DUT should be holding
// and the true integer running sum. This model is checked against the DUT on
// every cycle. Directed sequences pin the model with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_diff_integ;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         in_valid = 1'b0;
  logic [W:0]   in_data  = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef DIFF_INTEG_OVF_EN
  logic         overflow;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: the expected buffer contents in order, the wrapped
  // running sum and the sticky overflow flag.
  int expQ[$];
  int mAcc = 0;
  bit mOvf = 1'b0;

  diff_integ #(.INPUT_WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef DIFF_INTEG_OVF_EN
    .overflow_o  (overflow),
`endif
    .out_data_o  (out_data)
  );

  always #5 clk = ~clk;

  // Compares a single value and counts it.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, then waits until just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [W:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Applies reset for a short while, checks the reset values, then releases.
  task automatic doReset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_out_data", int'(out_data), 0);
`ifdef DIFF_INTEG_OVF_EN
    checkOutput("rst_overflow", int'(overflow), 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Model update on every edge. Transfers are taken from the handshake as
  // seen just before the edge. The model works with the true integer sum
  // and reduces it modulo 2^W.
  always @(posedge clk or negedge rst_n) begin : model
    int s;
    if (!rst_n) begin
      expQ.delete();
      mAcc = 0;
      mOvf = 1'b0;
    end else begin
      if (out_valid && out_ready && expQ.size() > 0) void'(expQ.pop_front());
      if (in_valid && in_ready) begin
        s = mAcc + int'($signed(in_data));
        if (s < 0 || s > MAXV) mOvf = 1'b1;
        mAcc = ((s % (MAXV + 1)) + (MAXV + 1)) % (MAXV + 1);
        expQ.push_back(mAcc);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid", int'(out_valid), int'(expQ.size() != 0));
      checkOutput("in_ready", int'(in_ready), int'(expQ.size() < 2));
      if (expQ.size() != 0) checkOutput("out_data", int'(out_data), expQ[0]);
`ifdef DIFF_INTEG_OVF_EN
      checkOutput("overflow", int'(overflow), int'(mOvf));
`endif
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int v;
    int r;

    // Round trip: +3,+5,-2,-6 -> 3,8,6,0, each one cycle after acceptance.
    doReset();
    applyStimulus(1'b1, 5'h03, 1'b1);
    checkOutput("rt_valid0", int'(out_valid), 1);
    checkOutput("rt_data0", int'(out_data), 3);
    applyStimulus(1'b1, 5'h05, 1'b1);
    checkOutput("rt_data1", int'(out_data), 8);
    applyStimulus(1'b1, 5'h1E, 1'b1);
    checkOutput("rt_data2", int'(out_data), 6);
    applyStimulus(1'b1, 5'h1A, 1'b1);
    checkOutput("rt_data3", int'(out_data), 0);
    checkOutput("rt_valid3", int'(out_valid), 1);
    applyStimulus(1'b0, 5'h00, 1'b1);
    checkOutput("rt_drained", int'(out_valid), 0);

    // Backpressure: only two of three offered samples get in.
    doReset();
    applyStimulus(1'b1, 5'h01, 1'b0);
    checkOutput("bp_ready1", int'(in_ready), 1);
    applyStimulus(1'b1, 5'h01, 1'b0);
    checkOutput("bp_ready2", int'(in_ready), 0);
    applyStimulus(1'b1, 5'h01, 1'b0);
    checkOutput("bp_ready3", int'(in_ready), 0);
    checkOutput("bp_head", int'(out_data), 1);
    applyStimulus(1'b1, 5'h01, 1'b1);
    checkOutput("bp_pop1", int'(out_data), 2);
    checkOutput("bp_release", int'(in_ready), 1);
    applyStimulus(1'b1, 5'h01, 1'b1);
    checkOutput("bp_third", int'(out_data), 3);
    applyStimulus(1'b0, 5'h00, 1'b1);
    checkOutput("bp_empty", int'(out_valid), 0);

    // Wrap: +15,+1 -> 15,0; then -1 -> 15.
    doReset();
    applyStimulus(1'b1, 5'h0F, 1'b1);
    checkOutput("wr_data0", int'(out_data), 15);
`ifdef DIFF_INTEG_OVF_EN
    checkOutput("wr_ovf0", int'(overflow), 0);
`endif
    applyStimulus(1'b1, 5'h01, 1'b1);
    checkOutput("wr_data1", int'(out_data), 0);
`ifdef DIFF_INTEG_OVF_EN
    checkOutput("wr_ovf1", int'(overflow), 1);
`endif
    applyStimulus(1'b1, 5'h1F, 1'b1);
    checkOutput("wr_data2", int'(out_data), 15);
`ifdef DIFF_INTEG_OVF_EN
    checkOutput("wr_ovf2", int'(overflow), 1);
`endif

    // Negative wrap: 0 + (-16) -> 0.
    doReset();
    applyStimulus(1'b1, 5'h10, 1'b1);
    checkOutput("nw_valid", int'(out_valid), 1);
    checkOutput("nw_data", int'(out_data), 0);
`ifdef DIFF_INTEG_OVF_EN
    checkOutput("nw_ovf", int'(overflow), 1);
`endif

    // Reset mid-stream with the buffer full.
    doReset();
    applyStimulus(1'b1, 5'h03, 1'b0);
    applyStimulus(1'b1, 5'h04, 1'b0);
    checkOutput("mr_full", int'(in_ready), 0);
    checkOutput("mr_head", int'(out_data), 3);
    doReset();
    applyStimulus(1'b1, 5'h07, 1'b1);
    checkOutput("mr_after", int'(out_data), 7);

    // Random traffic. in_data carries garbage while in_valid is low.
    doReset();
    for (int i = 0; i < 600; i++) begin
      v = $urandom_range(0, 2);
      r = $urandom_range(0, 3);
      applyStimulus(logic'(v != 0), (W+1)'($urandom_range(0, 31)), logic'(r != 0));
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, (W+1)'($urandom_range(0, 31)), 1'b1);
    checkOutput("rand_drained", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
